debounce_multi: RTL and testbench
=================================

Name: debounce_multi

Overview:
Parametrised successor to the single-input shift-register debouncer. It debounces CHANNELS independent push-button/switch inputs with a per-channel stable-sample counter, not a fixed 10-flop shift line. Each channel provides a clean level, one-shot rise and fall pulses, and an optional auto-repeat on the rise pulse while the input is held. It sits between board switches and the sequence-detector / FSM clock-enable logic.

Parameters:
CHANNELS, 4, number of independent inputs (1..32)
SYNC_STAGES, 2, synchroniser flops per channel (2..4)
PRESCALE, 1, clk_in cycles per sample tick (1 = sample every cycle)
STABLE_CNT, 8, consecutive agreeing samples required to change the debounced level (2..255)
REPEAT_DELAY, 0, samples held high before the first repeat pulse (0 = repeat disabled)
REPEAT_RATE, 16, samples between subsequent repeat pulses (>=1; ignored if REPEAT_DELAY=0)

Ports:
clk_in  input  1  single system clock, all logic on posedge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
D_in  input  CHANNELS  raw asynchronous switch inputs
D_level  output  CHANNELS  debounced level
D_out  output  CHANNELS  one-cycle pulse on debounced 0->1 edge, plus repeat pulses
D_fall  output  CHANNELS  one-cycle pulse on debounced 1->0 edge

Behaviour:
- Reset (reset=0, asynchronous): synchronisers, prescaler, all counters, and D_level/D_out/D_fall go to 0; FSMs go to LOW_STABLE. Reset applies immediately, including mid-count.
- Synchroniser: SYNC_STAGES flops per bit. s[i] is the last stage.
- Prescaler: counter 0..PRESCALE-1. tick=1 when the count is PRESCALE-1, then it wraps to 0. PRESCALE=1 gives tick every cycle. The prescaler is shared by all channels.
- Per-channel FSM, updated only on tick:
  - LOW_STABLE: s=1 -> LOW_CHK, cnt=1. s=0 -> stay.
  - LOW_CHK: s=0 -> LOW_STABLE, cnt=0. s=1 and cnt=STABLE_CNT-1 -> HIGH_STABLE, D_level=1, D_out pulse. Otherwise cnt+1.
  - HIGH_STABLE: s=0 -> HIGH_CHK, cnt=1. s=1 -> repeat logic.
  - HIGH_CHK: s=1 -> HIGH_STABLE, cnt=0; the repeat counter is NOT cleared. s=0 and cnt=STABLE_CNT-1 -> LOW_STABLE, D_level=0, D_fall pulse. Otherwise cnt+1.
- Any disagreeing sample restarts qualification, so a glitch shorter than STABLE_CNT samples never changes D_level.
- Latency, for PRESCALE=1: D_level and D_out go high on edge SYNC_STAGES+STABLE_CNT, counted from the first edge that samples D_in=1. The same rule applies to the fall edge.
- Outputs are registered. Pulses last exactly one clk_in cycle and coincide with the D_level change cycle.
- Repeat (REPEAT_DELAY>0):
  - rcnt counts ticks in HIGH_STABLE/HIGH_CHK and clears to 0 on entry to LOW_STABLE.
  - The first repeat D_out pulse fires when rcnt reaches REPEAT_DELAY. Subsequent pulses fire every REPEAT_RATE ticks.
  - rcnt saturates its period logic; it never wraps into a spurious pulse.
- Channels are fully independent. Simultaneous events on different channels all produce pulses in the same cycle.
- If D_in is held high through reset release, it is treated as a fresh press: D_out pulses after the full latency.
- Counter widths are $clog2 of the maximum value plus 1. There is no overflow path.

Decomposition:
- Package debounce_pkg holds:
  - the 2-bit FSM state encoding: LOW_STABLE=00, LOW_CHK=01, HIGH_STABLE=10, HIGH_CHK=11;
  - the counter-width function;
  - parameter legality checks, which fire a compile-time error on out-of-range values.
- Sub-module debounce_channel contains the synchroniser, FSM, stable counter and repeat counter for one bit.
- The top level holds the shared prescaler and a generate loop over CHANNELS.

Test Plan:
- Clean press, defaults: D_in[0] 0->1 held 20 cycles -> D_level[0]=1 and D_out[0] one-cycle pulse at edge 10, then D_in 1->0 -> D_fall[0] pulse 10 edges later; other channels stay 0.
- Bounce: D_in[1] toggles 1,0,1,1,0 (one cycle each), then stays 1 -> no output until 8 consecutive synced 1s; exactly one D_out[1] pulse.
- Prescale: PRESCALE=4, STABLE_CNT=3, D_in[2] held high -> D_level[2] rises within 2+3*4 cycles, within ±3 cycles of tick phase. A 7-cycle glitch produces no output.
- Repeat: REPEAT_DELAY=5, REPEAT_RATE=3, PRESCALE=1, D_in[3] held 30 cycles -> D_out[3] pulses at edge 10, then 15, 18, 21, 24, 27, ...; no pulses after release. D_fall[3] pulses once.
- Reset mid-operation: assert reset at cycle 6 of an 8-sample qualification -> all outputs 0 immediately. Release with D_in held 1 -> D_out pulse 10 edges after release.
- Simultaneous: all 4 inputs rise on the same edge -> D_out=4'b1111 for exactly one cycle, and D_level=4'b1111 from that cycle on.

Source files
------------

// File: rtl/debounce_pkg.sv
// Shared definitions for the multi-channel debouncer: per-channel state
// encoding, counter sizing helper and parameter range checking.
package debounce_pkg;

  // Per-channel qualification state. Bit 1 is the debounced level the
  // channel is currently holding; bit 0 marks a qualification in progress.
  typedef enum logic [1:0] {
    LOW_STABLE  = 2'b00,
    LOW_CHK     = 2'b01,
    HIGH_STABLE = 2'b10,
    HIGH_CHK    = 2'b11
  } db_state_t;

  // Width of a counter that must hold values 0..max_val, with one spare bit
  // so that comparisons never sit on a wrap boundary.
  function automatic int cnt_width(input int max_val);
    return $clog2(max_val) + 1;
  endfunction

  // True when every parameter lies inside its supported range.
  function automatic bit params_legal(input int channels,
                                      input int sync_stages,
                                      input int prescale,
                                      input int stable_cnt,
                                      input int repeat_delay,
                                      input int repeat_rate);
    return (channels >= 1) && (channels <= 32) &&
           (sync_stages >= 2) && (sync_stages <= 4) &&
           (prescale >= 1) &&
           (stable_cnt >= 2) && (stable_cnt <= 255) &&
           (repeat_delay >= 0) &&
           (repeat_rate >= 1);
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounced input: synchroniser, stable-sample FSM, stable counter and
// auto-repeat counter. The FSM only advances on the shared sample tick.
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int SYNC_STAGES  = 2,
  parameter int STABLE_CNT   = 8,
  parameter int REPEAT_DELAY = 0,
  parameter int REPEAT_RATE  = 16
) (
  input  logic      clk_in,
  input  logic      reset,
  input  logic      tick,
  input  logic      d_raw,
  output logic      d_level,
  output logic      d_out,
  output logic      d_fall,
  output db_state_t state_dbg
);

  localparam int CNT_W  = cnt_width(STABLE_CNT - 1);
  localparam int RCNT_W = cnt_width(REPEAT_DELAY + REPEAT_RATE - 1);
  localparam bit RPT_EN = (REPEAT_DELAY > 0);

  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(STABLE_CNT - 1);
  localparam logic [RCNT_W-1:0] RPT_FIRST = RCNT_W'(REPEAT_DELAY);
  localparam logic [RCNT_W-1:0] RPT_LAST  = RCNT_W'(REPEAT_DELAY + REPEAT_RATE - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  db_state_t              state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [RCNT_W-1:0]      rcnt_q, rcnt_d, rcnt_step;
  logic                   level_q, level_d;
  logic                   out_q, out_d;
  logic                   fall_q, fall_d;

  assign s = sync_q[SYNC_STAGES-1];

  // Register stage: synchroniser shift, FSM state, counters and outputs.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      sync_q  <= '0;
      state_q <= LOW_STABLE;
      cnt_q   <= '0;
      rcnt_q  <= '0;
      level_q <= 1'b0;
      out_q   <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], d_raw};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rcnt_q  <= rcnt_d;
      level_q <= level_d;
      out_q   <= out_d;
      fall_q  <= fall_d;
    end
  end

  // Next repeat count: climbs to the first-repeat point, then cycles over
  // one repeat period so it can never wrap back into a spurious pulse.
  always_comb begin
    rcnt_step = '0;
    if (RPT_EN) begin
      rcnt_step = (rcnt_q == RPT_LAST) ? RPT_FIRST : rcnt_q + RCNT_W'(1);
    end
  end

  // Qualification FSM: any disagreeing sample restarts the stable count.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rcnt_d  = rcnt_q;
    level_d = level_q;
    out_d   = 1'b0;
    fall_d  = 1'b0;
    if (tick) begin
      unique case (state_q)
        LOW_STABLE: begin
          if (s) begin
            state_d = LOW_CHK;
            cnt_d   = CNT_W'(1);
          end
        end
        LOW_CHK: begin
          if (!s) begin
            state_d = LOW_STABLE;
            cnt_d   = '0;
            rcnt_d  = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_d = HIGH_STABLE;
            cnt_d   = '0;
            level_d = 1'b1;
            out_d   = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        HIGH_STABLE: begin
          rcnt_d = rcnt_step;
          if (!s) begin
            state_d = HIGH_CHK;
            cnt_d   = CNT_W'(1);
          end else if (RPT_EN && (rcnt_step == RPT_FIRST)) begin
            out_d = 1'b1;
          end
        end
        HIGH_CHK: begin
          if (s) begin
            state_d = HIGH_STABLE;
            cnt_d   = '0;
            rcnt_d  = rcnt_step;
          end else if (cnt_q == CNT_LAST) begin
            state_d = LOW_STABLE;
            cnt_d   = '0;
            rcnt_d  = '0;
            level_d = 1'b0;
            fall_d  = 1'b1;
          end else begin
            cnt_d  = cnt_q + CNT_W'(1);
            rcnt_d = rcnt_step;
          end
        end
        default: state_d = LOW_STABLE;
      endcase
    end
  end

  assign d_level   = level_q;
  assign d_out     = out_q;
  assign d_fall    = fall_q;
  assign state_dbg = state_q;

endmodule

// File: rtl/debounce_multi.sv
// Multi-channel debouncer top: one shared sample prescaler feeding
// CHANNELS independent debounce_channel instances.
module debounce_multi
  import debounce_pkg::*;
#(
  parameter int CHANNELS     = 4,
  parameter int SYNC_STAGES  = 2,
  parameter int PRESCALE     = 1,
  parameter int STABLE_CNT   = 8,
  parameter int REPEAT_DELAY = 0,
  parameter int REPEAT_RATE  = 16
) (
  input  logic                  clk_in,
  input  logic                  reset,
  input  logic [CHANNELS-1:0]   D_in,
  output logic [CHANNELS-1:0]   D_level,
  output logic [CHANNELS-1:0]   D_out,
  output logic [CHANNELS-1:0]   D_fall,
  output logic [2*CHANNELS-1:0] state_dbg
);

  localparam int PS_W = cnt_width(PRESCALE - 1);
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

  if (!params_legal(CHANNELS, SYNC_STAGES, PRESCALE, STABLE_CNT,
                    REPEAT_DELAY, REPEAT_RATE)) begin : g_param_check
    $error("debounce_multi: parameter out of range");
  end

  logic [PS_W-1:0] pcnt_q;
  logic            tick;

  assign tick = (pcnt_q == PS_LAST);

  // Shared sample-tick prescaler, wraps to 0 on the tick cycle.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      pcnt_q <= '0;
    end else if (tick) begin
      pcnt_q <= '0;
    end else begin
      pcnt_q <= pcnt_q + PS_W'(1);
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    debounce_channel #(
      .SYNC_STAGES (SYNC_STAGES),
      .STABLE_CNT  (STABLE_CNT),
      .REPEAT_DELAY(REPEAT_DELAY),
      .REPEAT_RATE (REPEAT_RATE)
    ) u_ch (
      .clk_in   (clk_in),
      .reset    (reset),
      .tick     (tick),
      .d_raw    (D_in[i]),
      .d_level  (D_level[i]),
      .d_out    (D_out[i]),
      .d_fall   (D_fall[i]),
      .state_dbg(state_dbg[2*i +: 2])
    );
  end

endmodule

// File: tb/tb_debounce_multi.sv
// Directed bench for debounce_multi. Three instances share clock and reset:
// dut_a uses the defaults, dut_r enables auto-repeat (5/3), dut_p samples
// every 4th cycle with a 3-sample qualification. Edge k is the k-th posedge
// after the inputs were changed; outputs are sampled 1 time unit after it.
module tb_debounce_multi;

  logic       clk_in;
  logic       reset;
  logic [3:0] d_a, d_r, d_p;
  logic [3:0] lvl_a, out_a, fall_a;
  logic [3:0] lvl_r, out_r, fall_r;
  logic [3:0] lvl_p, out_p, fall_p;
  logic [7:0] dbg_a, dbg_r, dbg_p;

  int n_checks = 0;
  int n_errors = 0;

  logic [4:0] bnc;
  logic [3:0] exp_v;

  debounce_multi dut_a (
    .clk_in(clk_in), .reset(reset), .D_in(d_a),
    .D_level(lvl_a), .D_out(out_a), .D_fall(fall_a), .state_dbg(dbg_a)
  );

  debounce_multi #(.REPEAT_DELAY(5), .REPEAT_RATE(3)) dut_r (
    .clk_in(clk_in), .reset(reset), .D_in(d_r),
    .D_level(lvl_r), .D_out(out_r), .D_fall(fall_r), .state_dbg(dbg_r)
  );

  debounce_multi #(.PRESCALE(4), .STABLE_CNT(3)) dut_p (
    .clk_in(clk_in), .reset(reset), .D_in(d_p),
    .D_level(lvl_p), .D_out(out_p), .D_fall(fall_p), .state_dbg(dbg_p)
  );

  // Clock
  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    d_a   = '0;
    d_r   = '0;
    d_p   = '0;
    bnc   = 5'b01101;  // edges 1..5 drive 1,0,1,1,0

    // Reset state
    step();
    step();
    check("rst lvl_a", lvl_a, 0);
    check("rst out_a", out_a, 0);
    check("rst fall_a", fall_a, 0);
    check("rst dbg_a", dbg_a, 0);
    check("rst lvl_r", lvl_r, 0);
    check("rst dbg_r", dbg_r, 0);
    check("rst lvl_p", lvl_p, 0);
    check("rst dbg_p", dbg_p, 0);
    reset = 1'b1;
    step();

    // Clean press on channel 0: rise at edge 10, release after edge 20,
    // fall at edge 30.
    d_a[0] = 1'b1;
    for (int k = 1; k <= 34; k++) begin
      step();
      check($sformatf("clean out k=%0d", k), out_a, (k == 10) ? 4'b0001 : 4'b0000);
      check($sformatf("clean lvl k=%0d", k), lvl_a, (k >= 10 && k < 30) ? 4'b0001 : 4'b0000);
      check($sformatf("clean fall k=%0d", k), fall_a, (k == 30) ? 4'b0001 : 4'b0000);
      if (k == 20) d_a[0] = 1'b0;
    end

    // Bounce on channel 1: last 0 sampled at edge 5, so the 8 agreeing
    // samples complete at edge 15 with a single pulse.
    d_a[1] = bnc[0];
    for (int k = 1; k <= 22; k++) begin
      step();
      check($sformatf("bounce out k=%0d", k), out_a, (k == 15) ? 4'b0010 : 4'b0000);
      check($sformatf("bounce lvl k=%0d", k), lvl_a, (k >= 15) ? 4'b0010 : 4'b0000);
      d_a[1] = (k + 1 <= 5) ? bnc[k] : 1'b1;
    end
    d_a[1] = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      step();
      check($sformatf("bounce fall k=%0d", k), fall_a, (k == 10) ? 4'b0010 : 4'b0000);
    end
    check("bounce lvl released", lvl_a, 0);

    // Auto-repeat on dut_r channel 3: pulses 10,15,18,...,30; release after
    // edge 30 gives a single fall at edge 40.
    d_r[3] = 1'b1;
    for (int k = 1; k <= 45; k++) begin
      step();
      exp_v = (k == 10 || (k >= 15 && k <= 30 && (k - 15) % 3 == 0)) ? 4'b1000 : 4'b0000;
      check($sformatf("rpt out k=%0d", k), out_r, exp_v);
      check($sformatf("rpt lvl k=%0d", k), lvl_r, (k >= 10 && k < 40) ? 4'b1000 : 4'b0000);
      check($sformatf("rpt fall k=%0d", k), fall_r, (k == 40) ? 4'b1000 : 4'b0000);
      if (k == 30) d_r[3] = 1'b0;
    end

    // Reset mid-operation: channel 2 high, channel 0 six samples into its
    // qualification, then reset asserted between edges.
    d_a[2] = 1'b1;
    for (int k = 1; k <= 12; k++) step();
    check("pre-rst lvl_a", lvl_a, 4'b0100);
    d_a[0] = 1'b1;
    for (int k = 1; k <= 8; k++) step();
    check("pre-rst ch0 state", dbg_a[1:0], 2'b01);
    check("pre-rst ch2 state", dbg_a[5:4], 2'b10);
    d_p[2] = 1'b1;
    #2 reset = 1'b0;
    #1;
    check("mid-rst lvl_a", lvl_a, 0);
    check("mid-rst out_a", out_a, 0);
    check("mid-rst fall_a", fall_a, 0);
    check("mid-rst dbg_a", dbg_a, 0);
    step();
    step();
    reset = 1'b1;

    // Inputs held through release: dut_a pulses at edge 10; dut_p ticks on
    // edges 4, 8, 12 and qualifies on the third.
    for (int k = 1; k <= 20; k++) begin
      step();
      check($sformatf("post-rst out_a k=%0d", k), out_a, (k == 10) ? 4'b0101 : 4'b0000);
      check($sformatf("post-rst lvl_a k=%0d", k), lvl_a, (k >= 10) ? 4'b0101 : 4'b0000);
      check($sformatf("pre out_p k=%0d", k), out_p, (k == 12) ? 4'b0100 : 4'b0000);
      check($sformatf("pre lvl_p k=%0d", k), lvl_p, (k >= 12) ? 4'b0100 : 4'b0000);
    end

    // 7-cycle low glitch on prescaled channel 2: at most two ticks see it.
    d_p[2] = 1'b0;
    for (int k = 1; k <= 24; k++) begin
      step();
      check($sformatf("glitch lvl_p k=%0d", k), lvl_p, 4'b0100);
      check($sformatf("glitch fall_p k=%0d", k), fall_p, 4'b0000);
      if (k == 7) d_p[2] = 1'b1;
    end

    // Simultaneous rise on all four channels of dut_a.
    d_a = 4'b0000;
    for (int k = 1; k <= 14; k++) step();
    check("sim idle lvl_a", lvl_a, 0);
    d_a = 4'b1111;
    for (int k = 1; k <= 14; k++) begin
      step();
      check($sformatf("sim out k=%0d", k), out_a, (k == 10) ? 4'b1111 : 4'b0000);
      check($sformatf("sim lvl k=%0d", k), lvl_a, (k >= 10) ? 4'b1111 : 4'b0000);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
